muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_sign_adj.sv | 12 +
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and op-decode helpers for muldiv_unit.
package muldiv_pkg;

  localparam logic [1:0] MULDIV_MULT  = 2'b00;
  localparam logic [1:0] MULDIV_MULTU = 2'b01;
  localparam logic [1:0] MULDIV_DIV   = 2'b10;
  localparam logic [1:0] MULDIV_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MULDIV_MULT) || (op == MULDIV_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MULDIV_DIV) || (op == MULDIV_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sign_adj.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign correction.
module muldiv_sign_adj #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional build macro MULDIV_EARLY_OUT_EN ends MUL once the remaining multiplier bits are zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  muldiv_state_e      r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic               r_ready;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_last;
  logic               w_mul_done;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [2*WIDTH-1:0] w_prod_raw;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_sa = op_is_signed(op) & a[WIDTH-1];
  assign w_sb = op_is_signed(op) & b[WIDTH-1];

  muldiv_sign_adj #(.WIDTH(WIDTH)) u_abs_a (.i_val(a), .i_neg(w_sa), .o_val(w_abs_a));
  muldiv_sign_adj #(.WIDTH(WIDTH)) u_abs_b (.i_val(b), .i_neg(w_sb), .o_val(w_abs_b));

  // MUL: acc = {partial product, unprocessed multiplier}, shifted right once per step
  assign w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_add, r_acc[WIDTH-1:1]};

  // DIV: acc = {partial remainder, dividend/quotient}, shifted left once per step
  assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_opnd};
  assign w_div_nxt = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] r_mplr;
  logic [CNT_W-1:0] w_shamt;

  // Stopping early skips pure shift steps; apply the outstanding shifts in one go
  assign w_shamt    = CNT_W'(WIDTH - 1) - r_cnt;
  assign w_mul_done = w_last | ((r_mplr >> 1) == '0);
  assign w_prod_raw = w_mul_nxt >> w_shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_mplr <= '0;
    else if (r_state == ST_IDLE)
      r_mplr <= w_abs_b;
    else if (r_state == ST_MUL)
      r_mplr <= r_mplr >> 1;
  end
`else
  assign w_mul_done = w_last;
  assign w_prod_raw = w_mul_nxt;
`endif

  muldiv_sign_adj #(.WIDTH(2*WIDTH)) u_adj_prod (.i_val(w_prod_raw), .i_neg(r_neg_q), .o_val(w_prod));
  muldiv_sign_adj #(.WIDTH(WIDTH)) u_adj_quo (
    .i_val(w_div_nxt[WIDTH-1:0]), .i_neg(r_neg_q), .o_val(w_quo));
  muldiv_sign_adj #(.WIDTH(WIDTH)) u_adj_rem (
    .i_val(w_div_nxt[2*WIDTH-1:WIDTH]), .i_neg(r_neg_r), .o_val(w_rem));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_ready <= 1'b0;
      r_dbz   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !annul) begin
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            if (op_is_div(op)) begin
              if (b == '0) begin
                r_hi    <= a;
                r_lo    <= '1;
                r_ready <= 1'b1;
                r_dbz   <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_opnd  <= w_abs_b;
                r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                r_state <= ST_DIV;
              end
            end else begin
              r_opnd  <= w_abs_a;
              r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
              r_state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (annul) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_mul_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_mul_done) begin
              r_hi    <= w_prod[2*WIDTH-1:WIDTH];
              r_lo    <= w_prod[WIDTH-1:0];
              r_ready <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DIV: begin
          if (annul) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_div_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_hi    <= w_rem;
              r_lo    <= w_quo;
              r_ready <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign ready       = r_ready;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule
